conflict_serializer_rw: RTL and testbench
=========================================

Name: conflict_serializer_rw

Overview:
- Next-generation task dispatch serializer between a CQ slice and NUM_CORES cores.
- Holds an age-ordered ready list of dispatchable tasks and hands each core the oldest eligible task of the requested type.
- Never runs two conflicting tasks concurrently. Read-only (RO) tasks with equal hints may run together; read-write (RW) tasks are exclusive.
- Adds over the prior serializer: dynamic conflict evaluation, RO sharing, round-robin core arbitration, port-level almost-full threshold and a finish-error flag.

Parameters:
- NUM_CORES, 8, number of requesting cores.
- DEPTH, 16, ready-list entries (power of two not required, >=2).
- HINT_W, 32, hint width.
- TTYPE_W, 4, task-type width.
- TTYPE_ALL, 4'hF, request type value matching any task type.
- SLOT_W, 7, CQ slot index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enq_valid  in  1  CQ offers a task.
- enq_ready  out  1  task accepted when enq_valid&enq_ready.
- enq_ttype  in  TTYPE_W  task type.
- enq_hint  in  HINT_W  conflict hint.
- enq_ro  in  1  task is read-only.
- enq_slot  in  SLOT_W  CQ slot of the task.
- req_valid  in  NUM_CORES  per-core dequeue request (level).
- req_ttype  in  NUM_CORES*TTYPE_W  per-core requested type.
- resp_valid  out  NUM_CORES  one-hot grant, registered.
- resp_ttype/resp_hint/resp_ro/resp_slot  out  TTYPE_W/HINT_W/1/SLOT_W  granted task, registered.
- fin_valid  in  1  a core finished its task.
- fin_core  in  $clog2(NUM_CORES)  finishing core.
- af_thresh  in  $clog2(DEPTH+1)  almost-full threshold.
- almost_full  out  1  occupancy >= af_thresh.
- occupancy  out  $clog2(DEPTH+1)  valid entries.
- all_idle  out  1  no core holds a running task.
- err_fin_idle  out  1  sticky: fin for a core with no running task.

Behaviour:
- Reset (async, rst high): list empty, running table cleared, RR pointer=0.
  - Outputs: resp_valid=0, resp_* = 0, occupancy=0, enq_ready=1, almost_full=(af_thresh==0), all_idle=1, err_fin_idle=0.
- Ready list: compacted array, index 0 oldest. Each entry holds {ttype, hint, ro, slot}.
- Running table: per core {valid, hint, ro}.
- Finish masking: a core with fin_valid&fin_core==c in the current cycle is treated as not running for this cycle's eligibility.
- Entry i is eligible iff both hold:
  - No conflicting running task. Conflict = equal hints and (either side RW).
  - No older entry j<i with a conflicting hint under the same rule. This preserves per-hint order.
- Type match: req_ttype==TTYPE_ALL, or req_ttype==entry ttype.
- Core c is a candidate iff:
  - req_valid[c] is high;
  - resp_valid[c] was low last cycle;
  - it is not running, or it finishes this cycle;
  - an eligible matching entry exists.
- Grant: at most one per cycle.
  - Round-robin among candidates, starting at the RR pointer; pointer advances to winner+1 mod NUM_CORES.
  - The winner takes its oldest eligible matching entry.
- Grant latency: decided in cycle t. At the edge:
  - the entry is removed and younger entries shift down by one;
  - the running table for the winner is set {1, hint, ro};
  - resp_valid[winner] and resp_* are valid throughout cycle t+1 only.
- Between grants, resp_* hold their last value; resp_valid=0.
- Enqueue:
  - enq_ready = (occupancy<DEPTH). It does not depend on enq_valid and is not raised by a same-cycle dequeue.
  - An accepted task is appended behind all existing entries (accounting for a same-cycle shift).
  - It is first eligible the next cycle.
- Occupancy: +1 on accept, -1 on grant, unchanged on both.
- Finish: clears the core's running entry at the edge. fin for a non-running core is ignored and sets err_fin_idle; cleared only by reset.
- Simultaneous finish and grant to the same core: the grant wins and the entry becomes the new task.
- all_idle: registered view of running table == 0.
- Reset mid-operation discards all list contents and running state; no partial response is emitted.

Test Plan:
- Two RW tasks hint 0x5 then a task with hint 0x9; cores 0,1 request TTYPE_ALL.
  - Expect: core0 gets 0x5 at t+1, core1 gets 0x9 (second 0x5 blocked).
  - After fin core0, next request receives the second 0x5.
- Three RO tasks, hint 0x7; three cores request.
  - Expect: three grants on consecutive cycles, all hint 0x7.
  - Then an enqueued RW 0x7 is not granted until all three cores finish.
- Fill 16 entries → enq_ready=0, occupancy=16.
  - With af_thresh=8, almost_full rises on the 8th accept.
  - A grant with enq_valid high: occupancy 15 next cycle, enq_ready=1.
- Cores 2,5,6 all request with matching entries continuously.
  - Expect grant order 2,5,6,2 (round-robin); no core granted in two consecutive cycles.
- fin_valid with fin_core=3 while core 3 is idle → err_fin_idle=1 next cycle and stays high; running table unchanged.
- Assert rst mid-stream with occupancy 4 and two running tasks.
  - Expect immediate occupancy=0, all_idle=1, resp_valid=0.

Source files
------------

// File: rtl/conflict_serializer_rw.sv
// Task dispatch serializer: age-ordered ready list with hint-based conflict checking,
// read-only sharing and round-robin single-grant-per-cycle core arbitration.
module conflict_serializer_rw #(
    parameter int unsigned        NUM_CORES = 8,
    parameter int unsigned        DEPTH     = 16,
    parameter int unsigned        HINT_W    = 32,
    parameter int unsigned        TTYPE_W   = 4,
    parameter logic [TTYPE_W-1:0] TTYPE_ALL = {TTYPE_W{1'b1}},
    parameter int unsigned        SLOT_W    = 7,
    localparam int unsigned       CORE_W    = $clog2(NUM_CORES),
    localparam int unsigned       OCC_W     = $clog2(DEPTH + 1),
    localparam int unsigned       IDX_W     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [TTYPE_W-1:0]           enq_ttype,
    input  logic [HINT_W-1:0]            enq_hint,
    input  logic                         enq_ro,
    input  logic [SLOT_W-1:0]            enq_slot,
    input  logic [NUM_CORES-1:0]         req_valid,
    input  logic [NUM_CORES*TTYPE_W-1:0] req_ttype,
    output logic [NUM_CORES-1:0]         resp_valid,
    output logic [TTYPE_W-1:0]           resp_ttype,
    output logic [HINT_W-1:0]            resp_hint,
    output logic                         resp_ro,
    output logic [SLOT_W-1:0]            resp_slot,
    input  logic                         fin_valid,
    input  logic [CORE_W-1:0]            fin_core,
    input  logic [OCC_W-1:0]             af_thresh,
    output logic                         almost_full,
    output logic [OCC_W-1:0]             occupancy,
    output logic                         all_idle,
    output logic                         err_fin_idle
);

    logic [TTYPE_W-1:0]   lst_ttype_q [DEPTH];
    logic [TTYPE_W-1:0]   lst_ttype_d [DEPTH];
    logic [HINT_W-1:0]    lst_hint_q  [DEPTH];
    logic [HINT_W-1:0]    lst_hint_d  [DEPTH];
    logic                 lst_ro_q    [DEPTH];
    logic                 lst_ro_d    [DEPTH];
    logic [SLOT_W-1:0]    lst_slot_q  [DEPTH];
    logic [SLOT_W-1:0]    lst_slot_d  [DEPTH];
    logic [OCC_W-1:0]     count_q, count_d;

    logic [NUM_CORES-1:0] run_valid_q, run_valid_d;
    logic [NUM_CORES-1:0] run_ro_q, run_ro_d;
    logic [HINT_W-1:0]    run_hint_q [NUM_CORES];
    logic [HINT_W-1:0]    run_hint_d [NUM_CORES];
    logic [CORE_W-1:0]    rr_q, rr_d;

    logic [NUM_CORES-1:0] resp_valid_q, resp_valid_d;
    logic [TTYPE_W-1:0]   resp_ttype_q, resp_ttype_d;
    logic [HINT_W-1:0]    resp_hint_q, resp_hint_d;
    logic                 resp_ro_q, resp_ro_d;
    logic [SLOT_W-1:0]    resp_slot_q, resp_slot_d;
    logic                 err_q, err_d;
    logic                 all_idle_q, all_idle_d;

    logic [NUM_CORES-1:0] run_eff;
    logic [DEPTH-1:0]     elig;
    logic [NUM_CORES-1:0] cand;
    logic [IDX_W-1:0]     pick [NUM_CORES];
    logic                 grant;
    logic [CORE_W-1:0]    win;
    logic [IDX_W-1:0]     win_idx;
    logic [CORE_W-1:0]    rr_idx;
    int unsigned          rr_sum;
    logic                 accept;
    logic [OCC_W-1:0]     wr_idx;

    // A core finishing this cycle no longer blocks anything it conflicted with.
    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            run_eff[c] = run_valid_q[c] && !(fin_valid && fin_core == CORE_W'(c));
        end
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = OCC_W'(i) < count_q;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (run_eff[c] && run_hint_q[c] == lst_hint_q[i] && !(run_ro_q[c] && lst_ro_q[i])) begin
                    elig[i] = 1'b0;
                end
            end
            for (int j = 0; j < i; j++) begin
                if (lst_hint_q[j] == lst_hint_q[i] && !(lst_ro_q[j] && lst_ro_q[i])) begin
                    elig[i] = 1'b0;
                end
            end
        end
    end

    // Oldest eligible entry matching each core's requested type.
    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            cand[c] = 1'b0;
            pick[c] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (elig[i] && (req_ttype[c*TTYPE_W +: TTYPE_W] == TTYPE_ALL ||
                                req_ttype[c*TTYPE_W +: TTYPE_W] == lst_ttype_q[i])) begin
                    cand[c] = 1'b1;
                    pick[c] = IDX_W'(i);
                end
            end
            cand[c] = cand[c] && req_valid[c] && !resp_valid_q[c] && !run_eff[c];
        end
    end

    always_comb begin
        grant  = 1'b0;
        win    = '0;
        rr_sum = 0;
        rr_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            rr_sum = int'(rr_q) + k;
            if (rr_sum >= NUM_CORES) begin
                rr_sum = rr_sum - NUM_CORES;
            end
            rr_idx = CORE_W'(rr_sum);
            if (!grant && cand[rr_idx]) begin
                grant = 1'b1;
                win   = rr_idx;
            end
        end
        win_idx = pick[win];
    end

    always_comb begin
        lst_ttype_d = lst_ttype_q;
        lst_hint_d  = lst_hint_q;
        lst_ro_d    = lst_ro_q;
        lst_slot_d  = lst_slot_q;
        accept      = enq_valid && (count_q < OCC_W'(DEPTH));
        wr_idx      = count_q - OCC_W'(grant);

        if (grant) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= win_idx) begin
                    lst_ttype_d[i] = lst_ttype_q[i+1];
                    lst_hint_d[i]  = lst_hint_q[i+1];
                    lst_ro_d[i]    = lst_ro_q[i+1];
                    lst_slot_d[i]  = lst_slot_q[i+1];
                end
            end
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (OCC_W'(i) == wr_idx) begin
                    lst_ttype_d[i] = enq_ttype;
                    lst_hint_d[i]  = enq_hint;
                    lst_ro_d[i]    = enq_ro;
                    lst_slot_d[i]  = enq_slot;
                end
            end
        end
        count_d = count_q + OCC_W'(accept) - OCC_W'(grant);

        run_valid_d = run_valid_q;
        run_hint_d  = run_hint_q;
        run_ro_d    = run_ro_q;
        if (fin_valid) begin
            run_valid_d[fin_core] = 1'b0;
        end
        // A grant to a finishing core replaces its old task.
        if (grant) begin
            run_valid_d[win] = 1'b1;
            run_hint_d[win]  = lst_hint_q[win_idx];
            run_ro_d[win]    = lst_ro_q[win_idx];
        end
        all_idle_d = (run_valid_d == '0);
        err_d      = err_q || (fin_valid && !run_valid_q[fin_core]);

        resp_valid_d = '0;
        resp_ttype_d = resp_ttype_q;
        resp_hint_d  = resp_hint_q;
        resp_ro_d    = resp_ro_q;
        resp_slot_d  = resp_slot_q;
        rr_d         = rr_q;
        if (grant) begin
            resp_valid_d[win] = 1'b1;
            resp_ttype_d      = lst_ttype_q[win_idx];
            resp_hint_d       = lst_hint_q[win_idx];
            resp_ro_d         = lst_ro_q[win_idx];
            resp_slot_d       = lst_slot_q[win_idx];
            rr_d              = (win == CORE_W'(NUM_CORES - 1)) ? '0 : win + CORE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lst_ttype_q[i] <= '0;
                lst_hint_q[i]  <= '0;
                lst_ro_q[i]    <= 1'b0;
                lst_slot_q[i]  <= '0;
            end
            for (int c = 0; c < NUM_CORES; c++) begin
                run_hint_q[c] <= '0;
            end
            count_q      <= '0;
            run_valid_q  <= '0;
            run_ro_q     <= '0;
            rr_q         <= '0;
            resp_valid_q <= '0;
            resp_ttype_q <= '0;
            resp_hint_q  <= '0;
            resp_ro_q    <= 1'b0;
            resp_slot_q  <= '0;
            err_q        <= 1'b0;
            all_idle_q   <= 1'b1;
        end else begin
            lst_ttype_q  <= lst_ttype_d;
            lst_hint_q   <= lst_hint_d;
            lst_ro_q     <= lst_ro_d;
            lst_slot_q   <= lst_slot_d;
            run_hint_q   <= run_hint_d;
            count_q      <= count_d;
            run_valid_q  <= run_valid_d;
            run_ro_q     <= run_ro_d;
            rr_q         <= rr_d;
            resp_valid_q <= resp_valid_d;
            resp_ttype_q <= resp_ttype_d;
            resp_hint_q  <= resp_hint_d;
            resp_ro_q    <= resp_ro_d;
            resp_slot_q  <= resp_slot_d;
            err_q        <= err_d;
            all_idle_q   <= all_idle_d;
        end
    end

    assign enq_ready    = count_q < OCC_W'(DEPTH);
    assign almost_full  = count_q >= af_thresh;
    assign occupancy    = count_q;
    assign resp_valid   = resp_valid_q;
    assign resp_ttype   = resp_ttype_q;
    assign resp_hint    = resp_hint_q;
    assign resp_ro      = resp_ro_q;
    assign resp_slot    = resp_slot_q;
    assign all_idle     = all_idle_q;
    assign err_fin_idle = err_q;

endmodule

// File: tb/tb_conflict_serializer_rw.sv
// Bench for conflict_serializer_rw: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_conflict_serializer_rw;

    localparam int NC    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid;
    logic          enq_ready;
    logic [3:0]    enq_ttype;
    logic [31:0]   enq_hint;
    logic          enq_ro;
    logic [6:0]    enq_slot;
    logic [NC-1:0] req_valid;
    logic [31:0]   req_ttype;
    logic [NC-1:0] resp_valid;
    logic [3:0]    resp_ttype;
    logic [31:0]   resp_hint;
    logic          resp_ro;
    logic [6:0]    resp_slot;
    logic          fin_valid;
    logic [2:0]    fin_core;
    logic [4:0]    af_thresh;
    logic          almost_full;
    logic [4:0]    occupancy;
    logic          all_idle;
    logic          err_fin_idle;

    conflict_serializer_rw dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_ttype    (enq_ttype),
        .enq_hint     (enq_hint),
        .enq_ro       (enq_ro),
        .enq_slot     (enq_slot),
        .req_valid    (req_valid),
        .req_ttype    (req_ttype),
        .resp_valid   (resp_valid),
        .resp_ttype   (resp_ttype),
        .resp_hint    (resp_hint),
        .resp_ro      (resp_ro),
        .resp_slot    (resp_slot),
        .fin_valid    (fin_valid),
        .fin_core     (fin_core),
        .af_thresh    (af_thresh),
        .almost_full  (almost_full),
        .occupancy    (occupancy),
        .all_idle     (all_idle),
        .err_fin_idle (err_fin_idle)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ready list as a queue, running table as plain arrays.
    typedef struct packed {
        logic [3:0]  ttype;
        logic [31:0] hint;
        logic        ro;
        logic [6:0]  slot;
    } ent_t;

    ent_t          mq[$];
    logic [NC-1:0] m_run_v  = '0;
    logic [NC-1:0] m_run_ro = '0;
    logic [31:0]   m_run_h [NC];
    int            m_rr     = 0;
    logic [NC-1:0] m_resp_v = '0;
    logic [3:0]    m_r_tt   = '0;
    logic [31:0]   m_r_h    = '0;
    logic          m_r_ro   = 1'b0;
    logic [6:0]    m_r_slot = '0;
    logic          m_err    = 1'b0;

    function automatic bit conflicts(logic [31:0] h1, logic r1, logic [31:0] h2, logic r2);
        return (h1 == h2) && !(r1 && r2);
    endfunction

    function automatic bit busy(int c);
        return m_run_v[c] && !(fin_valid && int'(fin_core) == c);
    endfunction

    function automatic bit eligible(int i);
        for (int c = 0; c < NC; c++) begin
            if (busy(c) && conflicts(m_run_h[c], m_run_ro[c], mq[i].hint, mq[i].ro)) return 1'b0;
        end
        for (int j = 0; j < i; j++) begin
            if (conflicts(mq[j].hint, mq[j].ro, mq[i].hint, mq[i].ro)) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int         win;
        int         widx;
        int         c;
        int         found;
        bit         acc;
        ent_t       e;
        logic [3:0] rt;
        if (rst) begin
            mq.delete();
            m_run_v  = '0;
            m_run_ro = '0;
            for (int k = 0; k < NC; k++) m_run_h[k] = '0;
            m_rr     = 0;
            m_resp_v = '0;
            m_r_tt   = '0;
            m_r_h    = '0;
            m_r_ro   = 1'b0;
            m_r_slot = '0;
            m_err    = 1'b0;
        end else begin
            win  = -1;
            widx = -1;
            for (int k = 0; k < NC; k++) begin
                c = (m_rr + k) % NC;
                if (win < 0 && req_valid[c] && !m_resp_v[c] && !busy(c)) begin
                    rt    = req_ttype[c*4 +: 4];
                    found = -1;
                    for (int i = 0; i < mq.size(); i++) begin
                        if (found < 0 && eligible(i) && (rt == 4'hF || rt == mq[i].ttype)) found = i;
                    end
                    if (found >= 0) begin
                        win  = c;
                        widx = found;
                    end
                end
            end
            acc = enq_valid && (mq.size() < DEPTH);
            if (fin_valid) begin
                if (!m_run_v[fin_core]) m_err = 1'b1;
                m_run_v[fin_core] = 1'b0;
            end
            m_resp_v = '0;
            if (win >= 0) begin
                e              = mq[widx];
                m_run_v[win]   = 1'b1;
                m_run_h[win]   = e.hint;
                m_run_ro[win]  = e.ro;
                m_resp_v[win]  = 1'b1;
                m_r_tt         = e.ttype;
                m_r_h          = e.hint;
                m_r_ro         = e.ro;
                m_r_slot       = e.slot;
                mq.delete(widx);
                m_rr           = (win + 1) % NC;
            end
            if (acc) begin
                e.ttype = enq_ttype;
                e.hint  = enq_hint;
                e.ro    = enq_ro;
                e.slot  = enq_slot;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_resp_valid", 64'(resp_valid), 64'(m_resp_v));
        chk("cmp_resp_ttype", 64'(resp_ttype), 64'(m_r_tt));
        chk("cmp_resp_hint", 64'(resp_hint), 64'(m_r_h));
        chk("cmp_resp_ro", 64'(resp_ro), 64'(m_r_ro));
        chk("cmp_resp_slot", 64'(resp_slot), 64'(m_r_slot));
        chk("cmp_occupancy", 64'(occupancy), 64'(mq.size()));
        chk("cmp_enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
        chk("cmp_almost_full", 64'(almost_full), 64'(mq.size() >= int'(af_thresh)));
        chk("cmp_all_idle", 64'(all_idle), 64'(m_run_v == '0));
        chk("cmp_err_fin_idle", 64'(err_fin_idle), 64'(m_err));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [3:0] t, input logic [31:0] h, input logic r, input logic [6:0] s);
        enq_valid = 1'b1;
        enq_ttype = t;
        enq_hint  = h;
        enq_ro    = r;
        enq_slot  = s;
        cyc();
        enq_valid = 1'b0;
    endtask

    task automatic fin(input int c);
        fin_valid = 1'b1;
        fin_core  = 3'(c);
        cyc();
        fin_valid = 1'b0;
    endtask

    int rr_exp [4] = '{2, 5, 6, 2};

    initial begin
        rst       = 1'b1;
        enq_valid = 1'b0;
        enq_ttype = '0;
        enq_hint  = '0;
        enq_ro    = 1'b0;
        enq_slot  = '0;
        req_valid = '0;
        req_ttype = '1;
        fin_valid = 1'b0;
        fin_core  = '0;
        af_thresh = '0;
        #2;
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_almost_full_thr0", 64'(almost_full), 64'd1);
        chk("rst_all_idle", 64'(all_idle), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(err_fin_idle), 64'd0);
        cyc();
        cyc();
        rst       = 1'b0;
        af_thresh = 5'd8;
        cyc();

        // RW hint serialization
        enq(4'd1, 32'h5, 1'b0, 7'd1);
        enq(4'd1, 32'h5, 1'b0, 7'd2);
        enq(4'd1, 32'h9, 1'b0, 7'd3);
        req_valid = 8'b0000_0011;
        cyc();
        chk("t1_g0_valid", 64'(resp_valid), 64'h01);
        chk("t1_g0_hint", 64'(resp_hint), 64'h5);
        cyc();
        chk("t1_g1_valid", 64'(resp_valid), 64'h02);
        chk("t1_g1_hint", 64'(resp_hint), 64'h9);
        cyc();
        chk("t1_blocked", 64'(resp_valid), 64'h00);
        fin_valid = 1'b1;
        fin_core  = 3'd0;
        cyc();
        fin_valid = 1'b0;
        req_valid = '0;
        chk("t1_refill_valid", 64'(resp_valid), 64'h01);
        chk("t1_refill_slot", 64'(resp_slot), 64'd2);
        fin(0);
        fin(1);
        chk("t1_idle", 64'(all_idle), 64'd1);

        // RO sharing, then an RW task waits for all readers
        enq(4'd2, 32'h7, 1'b1, 7'd10);
        enq(4'd2, 32'h7, 1'b1, 7'd11);
        enq(4'd2, 32'h7, 1'b1, 7'd12);
        req_valid = 8'b0000_0111;
        cyc();
        chk("t2_ro_g1", 64'(resp_valid), 64'h02);
        chk("t2_ro_h1", 64'(resp_hint), 64'h7);
        cyc();
        chk("t2_ro_g2", 64'(resp_valid), 64'h04);
        cyc();
        chk("t2_ro_g0", 64'(resp_valid), 64'h01);
        chk("t2_ro_flag", 64'(resp_ro), 64'd1);
        req_valid = 8'b0000_1000;
        enq(4'd2, 32'h7, 1'b0, 7'd13);
        chk("t2_rw_wait_enq", 64'(resp_valid), 64'h00);
        fin(1);
        chk("t2_rw_wait_f1", 64'(resp_valid), 64'h00);
        fin(2);
        chk("t2_rw_wait_f2", 64'(resp_valid), 64'h00);
        fin(0);
        chk("t2_rw_grant", 64'(resp_valid), 64'h08);
        chk("t2_rw_slot", 64'(resp_slot), 64'd13);
        chk("t2_rw_ro", 64'(resp_ro), 64'd0);
        req_valid = '0;
        fin(3);

        // Fill to capacity with almost-full threshold 8
        for (int i = 0; i < DEPTH; i++) begin
            enq(4'd3, 32'h100 + 32'(i), 1'b0, 7'(32 + i));
            if (i == 6) chk("t3_af_below", 64'(almost_full), 64'd0);
            if (i == 7) chk("t3_af_rise", 64'(almost_full), 64'd1);
        end
        chk("t3_full_ready", 64'(enq_ready), 64'd0);
        chk("t3_full_occ", 64'(occupancy), 64'd16);
        enq_valid = 1'b1;
        enq_ttype = 4'd3;
        enq_hint  = 32'h200;
        enq_ro    = 1'b0;
        enq_slot  = 7'h7f;
        req_valid = 8'b0001_0000;
        cyc();
        enq_valid = 1'b0;
        req_valid = '0;
        chk("t3_deq_occ", 64'(occupancy), 64'd15);
        chk("t3_deq_ready", 64'(enq_ready), 64'd1);
        chk("t3_deq_valid", 64'(resp_valid), 64'h10);
        chk("t3_deq_hint", 64'(resp_hint), 64'h100);
        fin(4);

        // Round-robin among cores 2,5,6 (pointer brought to 2 via a core-1 grant)
        req_ttype = {8{4'd3}};
        req_valid = 8'b0000_0010;
        cyc();
        req_valid = '0;
        chk("t4_setup", 64'(resp_valid), 64'h02);
        fin(1);
        req_valid = 8'b0110_0100;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                fin_valid = 1'b1;
                fin_core  = 3'(rr_exp[k-1]);
            end
            cyc();
            fin_valid = 1'b0;
            chk("t4_rr_order", 64'(resp_valid), 64'd1 << rr_exp[k]);
        end
        req_valid = '0;
        fin(2);
        chk("t4_idle", 64'(all_idle), 64'd1);
        req_ttype = '1;

        // Finish for an idle core
        chk("t5_err_before", 64'(err_fin_idle), 64'd0);
        fin(3);
        chk("t5_err_set", 64'(err_fin_idle), 64'd1);
        chk("t5_idle_kept", 64'(all_idle), 64'd1);
        cyc();
        cyc();
        chk("t5_err_sticky", 64'(err_fin_idle), 64'd1);

        // Clean reset, then reset mid-stream with 4 queued and 2 running
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_err_cleared", 64'(err_fin_idle), 64'd0);
        for (int i = 0; i < 6; i++) enq(4'd5, 32'h30 + 32'(i), 1'b0, 7'(40 + i));
        req_valid = 8'b0000_0011;
        cyc();
        chk("t6_g0", 64'(resp_valid), 64'h01);
        cyc();
        chk("t6_g1", 64'(resp_valid), 64'h02);
        chk("t6_occ4", 64'(occupancy), 64'd4);
        chk("t6_busy", 64'(all_idle), 64'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_occ", 64'(occupancy), 64'd0);
        chk("t6_rst_idle", 64'(all_idle), 64'd1);
        chk("t6_rst_resp", 64'(resp_valid), 64'h00);
        req_valid = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
